// File: rtl/mem_pattern_axil_master.sv
// AXI4-Lite master that writes an address-derived pattern to a memory region,
// reads it back and flags any data or response error.
module mem_pattern_axil_master #(
    parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h40000000,
    parameter int unsigned C_M_AXI_ADDR_WIDTH   = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_M_TRANSACTIONS_NUM = 4
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            INIT_AXI_TXN,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam logic [31:0] PatternBase = 32'hA5A50000;
    localparam logic [8:0]  LastIdx = 9'(C_M_TRANSACTIONS_NUM - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

    state_e          state_q, state_d;
    logic [8:0]      idx_q, idx_d;
    logic            init_low_q;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            start;
    logic            last;
    logic [DW-1:0]   pattern_data;
    logic [AW-1:0]   word_addr;

    // init_low_q resets to 0 so a level held high through reset cannot start a run
    assign start        = INIT_AXI_TXN & init_low_q;
    assign last         = (idx_q == LastIdx);
    assign pattern_data = DW'(PatternBase) + DW'(idx_q);
    assign word_addr    = AW'(C_M_TARGET_BASE_ADDR) + AW'({idx_q, 2'b00});

    assign M_AXI_AWADDR  = word_addr;
    assign M_AXI_ARADDR  = word_addr;
    assign M_AXI_WDATA   = pattern_data;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_BREADY  = (state_q == StWrite);
    assign M_AXI_RREADY  = (state_q == StRead);
    assign TXN_DONE      = done_q;
    assign ERROR         = error_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        done_d    = done_q;
        error_d   = error_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StWrite;
                    idx_d     = '0;
                    error_d   = 1'b0;
                    done_d    = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            StWrite: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) error_d = 1'b1;
                    if (last) begin
                        idx_d     = '0;
                        state_d   = StRead;
                        arvalid_d = 1'b1;
                    end else begin
                        idx_d     = idx_q + 9'd1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            StRead: begin
                if (arvalid_q && M_AXI_ARREADY) arvalid_d = 1'b0;
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != pattern_data) error_d = 1'b1;
                    if (last) begin
                        idx_d   = '0;
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        idx_d     = idx_q + 9'd1;
                        arvalid_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            init_low_q <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            init_low_q <= ~INIT_AXI_TXN;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_mem_pattern_axil_master.sv
// Bench for mem_pattern_axil_master: a scripted AXI4-Lite slave plus directed
// scenarios with hand-computed addresses, data and flag values.
module tb_mem_pattern_axil_master;

    localparam logic [31:0] Base  = 32'h40000000;
    localparam int          Words = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic        txn_done, error;
    logic [31:0] awaddr, wdata, araddr;
    logic [31:0] rdata = '0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic        bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;

    always #5 clk = ~clk;

    mem_pattern_axil_master dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .INIT_AXI_TXN  (init),
        .TXN_DONE      (txn_done),
        .ERROR         (error),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // Slave configuration, written only by the stimulus process
    bit lag_mode = 1'b0;
    int bmax = 0, rmax = 0, corrupt_word = -1, berr_word = -1;

    // Slave state and transaction log, written only by the slave process
    logic [31:0] mem [256];
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_n = 0, aw_n = 0, w_n = 0, ar_n = 0, rd_n = 0;
    bit          aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    int          b_cnt = 0, r_cnt = 0, w_wait = 0, widx, ridx;
    logic [31:0] aw_lat, w_lat, r_addr;
    logic [1:0]  bresp_next = 2'b00;
    bit          s_awv = 0, s_wv = 0, s_bready = 0, s_arv = 0, s_rready = 0;
    logic [31:0] s_awaddr, s_wdata, s_araddr;

    // Runs on the falling edge: snapshots hold what the DUT presented at the
    // rising edge just passed, so handshakes are decided from them.
    always @(negedge clk) begin
        if (!rst_n) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; w_wait = 0;
            bvalid = 1'b0; rvalid = 1'b0;
            awready = 1'b0; wready = 1'b0; arready = 1'b0;
            s_awv = 0; s_wv = 0; s_bready = 0; s_arv = 0; s_rready = 0;
        end else begin
            if (s_bready && bvalid) begin bvalid = 1'b0; b_pend = 0; end
            if (s_rready && rvalid) begin rvalid = 1'b0; r_pend = 0; rd_n++; end
            if (s_awv && awready) begin aw_got = 1; aw_lat = s_awaddr; aw_n++; end
            if (s_wv && wready) begin w_got = 1; w_lat = s_wdata; w_n++; w_wait = 0; end
            if (s_arv && arready) begin
                r_pend = 1; r_addr = s_araddr; ar_n++;
                r_cnt = int'($urandom_range(32'(rmax), 0));
            end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0;
                widx = int'((aw_lat - Base) >> 2) & 255;
                mem[widx] = w_lat;
                wr_addr[wr_n % 64] = aw_lat;
                wr_data[wr_n % 64] = w_lat;
                wr_n++;
                b_pend = 1;
                b_cnt = int'($urandom_range(32'(bmax), 0));
                bresp_next = (widx == berr_word) ? 2'b10 : 2'b00;
            end
            if (b_pend && !bvalid) begin
                if (b_cnt == 0) begin bvalid = 1'b1; bresp = bresp_next; end
                else b_cnt--;
            end
            if (r_pend && !rvalid) begin
                if (r_cnt == 0) begin
                    ridx = int'((r_addr - Base) >> 2) & 255;
                    rvalid = 1'b1;
                    rresp = 2'b00;
                    rdata = (ridx == corrupt_word) ? 32'hDEADBEEF : mem[ridx];
                end else r_cnt--;
            end
            if (lag_mode) begin
                // AWREADY follows AWVALID at once; WREADY trails it by 3 cycles
                awready = awvalid && !aw_got;
                if (wvalid && !w_got) w_wait++;
                wready  = wvalid && !w_got && (w_wait >= 4);
                arready = arvalid;
            end else begin
                awready = 1'b1; wready = 1'b1; arready = 1'b1;
            end
            s_awv = awvalid; s_awaddr = awaddr;
            s_wv = wvalid;   s_wdata = wdata;
            s_bready = bready;
            s_arv = arvalid; s_araddr = araddr;
            s_rready = rready;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_run(input string name, input bit glitch);
        int cyc;
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        check({name, "_start_clears"}, 32'({txn_done, error}), 32'd0);
        check({name, "_start_valids"}, 32'({awvalid, wvalid}), 32'b11);
        if (glitch) begin
            // a second rising edge while writing must be ignored
            repeat (2) @(negedge clk);
            init = 1'b0;
            @(negedge clk);
            init = 1'b1;
        end
        cyc = 0;
        while (!txn_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_txn_done"}, 32'(txn_done), 32'd1);
    endtask

    task automatic scenario(input string name, input bit glitch, input bit exp_err);
        int b_wr, b_aw, b_w, b_ar, b_rd;
        b_wr = wr_n; b_aw = aw_n; b_w = w_n; b_ar = ar_n; b_rd = rd_n;
        start_run(name, glitch);
        repeat (3) @(negedge clk);
        init = 1'b0;
        repeat (2) @(negedge clk);
        check({name, "_done_held"}, 32'(txn_done), 32'd1);
        check({name, "_error"}, 32'(error), 32'(exp_err));
        check({name, "_aw_count"}, 32'(aw_n - b_aw), 32'(Words));
        check({name, "_w_count"}, 32'(w_n - b_w), 32'(Words));
        check({name, "_ar_count"}, 32'(ar_n - b_ar), 32'(Words));
        check({name, "_r_count"}, 32'(rd_n - b_rd), 32'(Words));
        for (int k = 0; k < Words; k++) begin
            check($sformatf("%s_addr%0d", name, k), wr_addr[(b_wr + k) % 64], Base + 32'(4 * k));
            check($sformatf("%s_data%0d", name, k), wr_data[(b_wr + k) % 64],
                  32'hA5A50000 + 32'(k));
        end
    endtask

    initial begin
        int cyc;
        int b_aw;
        bit seen;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({awvalid, wvalid, bready, arvalid, rready, txn_done, error}), 32'd0);
        check("const_prot_strb", 32'({awprot, arprot, wstrb}), 32'h00F);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", 32'({awvalid, txn_done}), 32'd0);

        // Ideal slave
        scenario("ideal", 1'b0, 1'b0);

        // Lagging WREADY, random B/R latency, ignored restart edge mid-write
        lag_mode = 1'b1; bmax = 5; rmax = 5;
        scenario("lag", 1'b1, 1'b0);

        // Corrupted read of word 2
        lag_mode = 1'b0; bmax = 0; rmax = 0; corrupt_word = 2;
        scenario("corrupt", 1'b0, 1'b1);
        corrupt_word = -1;

        // SLVERR on write 1, then a clean rerun clears ERROR
        berr_word = 1;
        scenario("bresp", 1'b0, 1'b1);
        berr_word = -1;
        scenario("rerun", 1'b0, 1'b0);

        // Reset while reading word 1 with INIT held high throughout
        @(negedge clk);
        init = 1'b1;
        cyc = 0;
        while (!(arvalid && araddr == Base + 32'd4) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reach_read1", araddr, Base + 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs",
              32'({awvalid, wvalid, bready, arvalid, rready, txn_done, error}), 32'd0);
        rst_n = 1'b1;
        b_aw = aw_n;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (awvalid || arvalid) seen = 1'b1;
        end
        check("rst_no_level_start", 32'({seen, 8'(aw_n - b_aw)}), 32'd0);
        init = 1'b0;
        @(negedge clk);
        scenario("post_rst", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
